// File: rtl/data_mem_arbiter.sv
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Shares a single-port synchronous-read data memory between the
//             pipeline MEM stage (priority) and a debug/DMA port. A
//             starvation counter guarantees the debug port a slot. Read data
//             returns one cycle after grant and is routed to its owner.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_read,
    input  logic                     p_write,
    input  logic [ADDRESS_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0]    p_wdata,
    output logic                     p_stall,
    output logic [DATA_WIDTH-1:0]    p_rdata,
    input  logic                     d_valid,
    input  logic                     d_write,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_ready,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic       w_p_req;
    logic       w_limit_hit;
    logic       w_grant_p;
    logic       w_grant_d;
    logic [3:0] r_starve_cnt;
    own_t       r_ret_own;

    // Grant decision; everything is held off while reset is asserted (rst low)
    assign w_p_req     = p_read | p_write;
    assign w_limit_hit = (r_starve_cnt == C_STARVE_LIMIT);
    assign w_grant_d   = rst & d_valid & (~w_p_req | w_limit_hit);
    assign w_grant_p   = rst & w_p_req & ~w_grant_d;

    assign p_stall = rst & w_p_req & ~w_grant_p;
    assign d_ready = w_grant_d;

    // Steer the memory port from whichever requester holds the grant
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_p) begin
            mem_en    = 1'b1;
            mem_we    = p_write;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end else if (w_grant_d) begin
            mem_en    = 1'b1;
            mem_we    = d_write;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Count consecutive cycles the debug port loses to the pipeline, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!d_valid || w_grant_d) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_p && !w_limit_hit) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Remember who owns the read data arriving from memory next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ret_own <= OWN_NONE;
        end else if (w_grant_p && !p_write) begin
            r_ret_own <= OWN_P;
        end else if (w_grant_d && !d_write) begin
            r_ret_own <= OWN_D;
        end else begin
            r_ret_own <= OWN_NONE;
        end
    end

    assign p_rdata  = (r_ret_own == OWN_P) ? mem_rdata : '0;
    assign d_rvalid = (r_ret_own == OWN_D);
    assign d_rdata  = (r_ret_own == OWN_D) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Self-checking bench for data_mem_arbiter: directed vectors, a
//             behavioural reference model with its own memory image, and a
//             per-cycle compare process.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    localparam int DW     = 20;
    localparam int AW     = 8;
    localparam int STARVE = 4;

    logic          clk;
    logic          rst;
    logic          p_read, p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_stall;
    logic [DW-1:0] p_rdata;
    logic          d_valid, d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p_read   (p_read),
        .p_write  (p_write),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_stall  (p_stall),
        .p_rdata  (p_rdata),
        .d_valid  (d_valid),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port memory driven by the DUT
    logic [DW-1:0] dmem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= dmem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:255];
    int            d_lost;      // cycles the current debug request has been refused
    int            pend_owner;  // 0 none, 1 pipeline, 2 debug
    logic [DW-1:0] pend_data;

    // Check outputs mid-cycle, then advance the model to the next cycle
    always @(negedge clk) begin
        bit            preq, gp, gd, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        if (!rst) begin
            chk("rst_p_stall",  p_stall,  0);
            chk("rst_d_ready",  d_ready,  0);
            chk("rst_mem_en",   mem_en,   0);
            chk("rst_mem_we",   mem_we,   0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_d_rdata",  d_rdata,  0);
            chk("rst_p_rdata",  p_rdata,  0);
            d_lost     = 0;
            pend_owner = 0;
        end else begin
            preq   = p_read | p_write;
            gd     = d_valid && (!preq || d_lost >= STARVE);
            gp     = preq && !gd;
            e_we   = gp ? p_write : (gd ? d_write : 1'b0);
            e_addr = gp ? p_addr  : d_addr;
            e_wd   = gp ? p_wdata : d_wdata;
            chk("m_p_stall", p_stall, preq && !gp);
            chk("m_d_ready", d_ready, gd);
            chk("m_mem_en",  mem_en,  gp || gd);
            chk("m_mem_we",  mem_we,  e_we);
            if (gp || gd) chk("m_mem_addr", mem_addr, e_addr);
            if (e_we)     chk("m_mem_wdata", mem_wdata, e_wd);
            chk("m_p_rdata",  p_rdata,  pend_owner == 1 ? pend_data : '0);
            chk("m_d_rvalid", d_rvalid, pend_owner == 2);
            chk("m_d_rdata",  d_rdata,  pend_owner == 2 ? pend_data : '0);
            // advance
            if (!d_valid || gd) d_lost = 0;
            else                d_lost = d_lost + 1;
            pend_owner = 0;
            if ((gp || gd) && !e_we) begin
                pend_owner = gp ? 1 : 2;
                pend_data  = ref_mem[e_addr];
            end
            if ((gp || gd) && e_we) ref_mem[e_addr] = e_wd;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_read = 0; p_write = 0; p_addr = '0; p_wdata = '0;
        d_valid = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    endtask

    initial begin
        logic [5:0] rdy_pat, stall_pat;
        bit         d_done;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_rdata  = '0;
        d_lost     = 0;
        pend_owner = 0;
        pend_data  = '0;
        rst = 0;
        idle();
        tick(); tick();
        #1;
        chk("reset_p_stall", p_stall, 0);
        chk("reset_d_rvalid", d_rvalid, 0);
        rst = 1;
        tick();

        // Pipeline only: write then read back
        p_write = 1; p_addr = 8'h10; p_wdata = 20'h0ABCD;
        #1 chk("pw_mem_we", mem_we, 1); chk("pw_stall", p_stall, 0);
        tick();
        p_write = 0; p_read = 1;
        #1 chk("pr_stall", p_stall, 0);
        tick();
        idle();
        #1 chk("pr_rdata", p_rdata, 20'h0ABCD); chk("pr_no_drvalid", d_rvalid, 0);
        tick();

        // Debug only: write then read back
        d_valid = 1; d_write = 1; d_addr = 8'hFF; d_wdata = 20'hFFFFF;
        #1 chk("dw_ready", d_ready, 1);
        tick();
        d_write = 0;
        #1 chk("dr_ready", d_ready, 1);
        tick();
        idle();
        #1 chk("dr_rvalid", d_rvalid, 1); chk("dr_rdata", d_rdata, 20'hFFFFF);
        tick();

        // Starvation: continuous pipeline reads with a pending debug read
        d_done = 0; rdy_pat = '0; stall_pat = '0;
        for (int c = 0; c < 6; c++) begin
            p_read = 1; p_addr = 8'h10;
            d_valid = !d_done; d_write = 0; d_addr = 8'hFF;
            #1;
            rdy_pat[c]   = d_ready;
            stall_pat[c] = p_stall;
            if (c == 5) begin
                chk("starve_d_rvalid", d_rvalid, 1);
                chk("starve_d_rdata", d_rdata, 20'hFFFFF);
            end
            if (d_ready) d_done = 1;
            tick();
        end
        chk("starve_ready_pattern", 32'(rdy_pat), 32'b010000);
        chk("starve_stall_pattern", 32'(stall_pat), 32'b010000);
        // Counter restarted: a fresh debug request loses to the pipeline
        d_valid = 1;
        #1 chk("starve_restart_ready", d_ready, 0);
        tick();
        idle();
        tick();

        // Simultaneous writes, counter below limit
        p_write = 1; p_addr = 8'h20; p_wdata = 20'h00001;
        d_valid = 1; d_write = 1; d_addr = 8'h30; d_wdata = 20'h00002;
        #1 chk("sim_p_stall", p_stall, 0); chk("sim_d_ready", d_ready, 0);
        chk("sim_addr_p", mem_addr, 8'h20);
        tick();
        p_write = 0;
        #1 chk("sim_d_ready2", d_ready, 1); chk("sim_addr_d", mem_addr, 8'h30);
        tick();
        idle(); p_read = 1; p_addr = 8'h30;
        tick();
        idle();
        #1 chk("sim_readback", p_rdata, 20'h00002);
        tick();

        // Read and write both high act as a write
        p_read = 1; p_write = 1; p_addr = 8'h40; p_wdata = 20'h00005;
        #1 chk("rw_mem_we", mem_we, 1);
        tick();
        idle();
        #1 chk("rw_no_return", p_rdata, 0); chk("rw_no_drvalid", d_rvalid, 0);
        p_read = 1; p_addr = 8'h40;
        tick();
        idle();
        #1 chk("rw_readback", p_rdata, 20'h00005);
        tick();

        // Reset in the cycle after a debug read grant
        d_valid = 1; d_write = 0; d_addr = 8'hFF;
        tick();
        idle(); p_read = 1; p_addr = 8'h10;
        rst = 0;
        #1 chk("rmid_d_rvalid", d_rvalid, 0); chk("rmid_mem_en", mem_en, 0);
        chk("rmid_p_stall", p_stall, 0);
        tick(); tick();
        rst = 1;
        #1 chk("rrel_no_drvalid", d_rvalid, 0); chk("rrel_p_stall", p_stall, 0);
        chk("rrel_mem_en", mem_en, 1);
        tick();
        idle();
        #1 chk("rrel_p_rdata", p_rdata, 20'h0ABCD); chk("rrel_no_drvalid2", d_rvalid, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
